regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Architectural integer register file for the RV32I core, sitting at the write-back end of the MEM/WB pipeline register.
- Consumes the write-back bundle (waddr/we/wdata) and serves two read ports to ID.
- Write-to-read bypass in the same cycle; x0 hardwired to zero.
- Per-register pending-write scoreboard: ID increments an entry when it issues a register writer, WB decrements it on retire. ID uses the busy flags to detect unresolved producers.

Parameters:
- REG_NUM, 32, number of architectural registers (index 0 hardwired zero)
- DATA_W, 32, register data width
- PEND_W, 3, width of each pending-write counter (max in flight = 2^PEND_W-1 = 7)

Ports:
- clk  input  1  core clock, all state updates on posedge
- rst  input  1  synchronous active-high reset (`RstEnable)
- we  input  1  write-back enable, from MEM/WB wb_wreg
- waddr  input  5  write-back destination, from wb_wd
- wdata  input  DATA_W  write-back data, from wb_wdata
- re1  input  1  read port 1 enable
- raddr1  input  5  read port 1 address
- rdata1  output  DATA_W  read port 1 data (combinational)
- busy1  output  1  raddr1 has an unretired pending writer
- re2  input  1  read port 2 enable
- raddr2  input  5  read port 2 address
- rdata2  output  DATA_W  read port 2 data (combinational)
- busy2  output  1  raddr2 has an unretired pending writer
- iss_valid  input  1  ID issues an instruction that writes iss_wd
- iss_wd  input  5  destination of the issuing instruction
- iss_full  output  1  pend[iss_wd] saturated; ID must stall and not count the issue
- flush  input  1  discard all in-flight writers (branch mispredict); clears scoreboard
- sb_err  output  1  sticky scoreboard error (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge): regs[1..31]<=0, all pend<=0, sb_err<=0. While rst=1, rdata1/2=0, busy1/2=0, iss_full=0.
- Write: at posedge, if we=1 and waddr!=0, regs[waddr]<=wdata. Writes to x0 are dropped. flush does not suppress the write.
- Read port n (combinational), priority order:
  - rst: 0
  - re_n=0: 0
  - raddr_n=0: 0
  - we=1 and waddr=raddr_n: wdata (bypass)
  - otherwise: regs[raddr_n]
- Both ports are independent; same address on both returns identical data.
- busy_n = re_n && raddr_n!=0 && pend[raddr_n]!=0 && !(we && waddr==raddr_n && pend[raddr_n]==1). A retiring last writer is not busy, since bypass supplies its data.
- iss_full = iss_valid && iss_wd!=0 && pend[iss_wd]==max.
- Counter update per register r!=0, at posedge, when not rst:
  - flush=1: pend[r]<=0 for all r. An issue or retire in the same cycle is ignored.
  - inc = iss_valid && iss_wd==r && !iss_full
  - dec = we && waddr==r && pend[r]!=0
  - inc and dec together: unchanged. inc only: +1. dec only: -1.
  - pend[0] is constant 0.
- Retire with pend=0 (underflow, e.g. after a flush) is not decremented.
- Write latency 1 cycle; bypass and read latency 0.

Optional Feature:
- Macro REGFILE_SB_CHECK_EN.
- Defined: sb_err is set sticky (until rst) when either of these occurs without a concurrent flush:
  - we && waddr!=0 && pend[waddr]==0 (retire without an issue)
  - iss_valid && iss_full
- Undefined: sb_err is tied 0 and the check logic is absent.

Decomposition:
- Shared defines, in the existing defines file: RegAddrBus, RegBus, ZeroWord, NOPRegAddr, WriteEnable/WriteDisable, ReadEnable, RstEnable, plus a new PendBus and PEND_MAX.
- One natural sub-module, regfile_pend_cnt: a single saturating up/down counter with inc, dec, clr, cnt and is_max ports. It is instantiated REG_NUM-1 times through a generate loop.

Test Plan:
- Reset then read: rst for 2 cycles, then re1=1 raddr1=5 → rdata1=0, busy1=0. Write we=1 waddr=0 wdata=0xDEADBEEF → a later read of x0 returns 0.
- Bypass: we=1 waddr=7 wdata=0x12345678 with re1=1 raddr1=7 in the same cycle → rdata1=0x12345678 that cycle; next cycle, with we=0, rdata1 is still 0x12345678.
- Scoreboard: iss_valid iss_wd=3 in cycles 1 and 2 → pend[3]=2 and busy on reads of x3. Retire we waddr=3 in cycle 4 → busy stays 1. In cycle 5, during the second retire, busy=0 and rdata shows wdata.
- Simultaneous issue and retire on x9 with pend=1 → pend stays 1, busy stays 1.
- Saturation: issue x4 seven times → iss_full=1 on the eighth issue, pend stays 7. With REGFILE_SB_CHECK_EN, sb_err=1 the next cycle.
- Flush: pend[2]=2 and pend[5]=1, then flush=1 with concurrent we waddr=2 wdata=0xA5 → all pend=0, regs[2]=0xA5, busy=0. A later retire to x2 leaves pend at 0 and sets sb_err with the macro defined, 0 without.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the register file: address/bus widths, reset and enable levels.
// Imported by regfile_sb and regfile_pend_cnt.
package regfile_sb_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t NOP_REG_ADDR = '0;
    localparam logic      RST_ENABLE   = 1'b1;
    localparam logic      WRITE_ENABLE = 1'b1;
    localparam logic      READ_ENABLE  = 1'b1;

    // Largest value a pending-write counter of the given width can hold.
    function automatic int pend_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/regfile_pend_cnt.sv
// Saturating up/down pending-write counter for one architectural register.
// Latency: 1 cycle (cnt updates at posedge). Backpressure: is_max tells the issuer to stall.
// clr has priority over inc/dec; inc together with dec leaves cnt unchanged.
module regfile_pend_cnt
    import regfile_sb_pkg::*;
#(
    parameter int PEND_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    input  logic              clr,
    output logic [PEND_W-1:0] cnt,
    output logic              is_max
);

    localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(pend_max(PEND_W));

    assign is_max = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || clr) begin
            cnt <= '0;
        end else if (inc && !dec && !is_max) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// RV32I register file with same-cycle write bypass, x0 hardwired zero, and per-register pending-write scoreboard.
// Latency: reads/bypass 0 cycles, writes 1 cycle. Backpressure: iss_full stalls ID when a counter saturates.
// Optional sticky scoreboard error checking is built when REGFILE_SB_CHECK_EN is defined.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32,
    parameter int PEND_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  reg_addr_t         waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  reg_addr_t         raddr1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy1,
    input  logic              re2,
    input  reg_addr_t         raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy2,
    input  logic              iss_valid,
    input  reg_addr_t         iss_wd,
    output logic              iss_full,
    input  logic              flush,
    output logic              sb_err
);

    logic [DATA_W-1:0] regs     [REG_NUM];
    logic [PEND_W-1:0] pend     [REG_NUM];
    logic [REG_NUM-1:0] pend_max_v;

    // Architectural state; x0 only ever sees the reset value.
    always_ff @(posedge clk) begin
        for (int i = 0; i < REG_NUM; i++) begin
            if (rst == RST_ENABLE) begin
                regs[i] <= '0;
            end else if (we == WRITE_ENABLE && i != 0 && waddr == REG_ADDR_W'(i)) begin
                regs[i] <= wdata;
            end
        end
    end

    assign iss_full = (rst != RST_ENABLE) && iss_valid && (iss_wd != NOP_REG_ADDR) && pend_max_v[iss_wd];

    for (genvar r = 0; r < REG_NUM; r++) begin : g_pend
        if (r == 0) begin : g_zero
            assign pend[r]       = '0;
            assign pend_max_v[r] = 1'b0;
        end else begin : g_cnt
            logic inc;
            logic dec;
            // A flush wins over any same-cycle issue or retire.
            assign inc = !flush && iss_valid && (iss_wd == REG_ADDR_W'(r)) && !iss_full;
            assign dec = !flush && we && (waddr == REG_ADDR_W'(r)) && (pend[r] != '0);

            regfile_pend_cnt #(.PEND_W(PEND_W)) u_cnt (
                .clk    (clk),
                .rst    (rst),
                .inc    (inc),
                .dec    (dec),
                .clr    (flush),
                .cnt    (pend[r]),
                .is_max (pend_max_v[r])
            );
        end
    end

    function automatic logic [DATA_W-1:0] read_sel(
        input logic              rst_i,
        input logic              re,
        input reg_addr_t         ra,
        input logic              we_i,
        input reg_addr_t         wa,
        input logic [DATA_W-1:0] wd,
        input logic [DATA_W-1:0] rv
    );
        if (rst_i == RST_ENABLE || re != READ_ENABLE || ra == NOP_REG_ADDR) return '0;
        if (we_i == WRITE_ENABLE && wa == ra) return wd;
        return rv;
    endfunction

    // The last outstanding writer retiring this cycle is served by the bypass, so it is not busy.
    function automatic logic busy_sel(
        input logic              rst_i,
        input logic              re,
        input reg_addr_t         ra,
        input logic              we_i,
        input reg_addr_t         wa,
        input logic [PEND_W-1:0] pc
    );
        return (rst_i != RST_ENABLE) && re && (ra != NOP_REG_ADDR) && (pc != '0)
               && !(we_i && (wa == ra) && (pc == PEND_W'(1)));
    endfunction

    assign rdata1 = read_sel(rst, re1, raddr1, we, waddr, wdata, regs[raddr1]);
    assign rdata2 = read_sel(rst, re2, raddr2, we, waddr, wdata, regs[raddr2]);
    assign busy1  = busy_sel(rst, re1, raddr1, we, waddr, pend[raddr1]);
    assign busy2  = busy_sel(rst, re2, raddr2, we, waddr, pend[raddr2]);

`ifdef REGFILE_SB_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            sb_err <= 1'b0;
        end else if (!flush && ((we && waddr != NOP_REG_ADDR && pend[waddr] == '0)
                                || (iss_valid && iss_full))) begin
            sb_err <= 1'b1;
        end
    end
`else
    assign sb_err = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_regfile_sb;

`ifdef REGFILE_SB_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    localparam logic [5:0] M_ALL = 6'h3F;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        busy1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        busy2;
    logic        iss_valid;
    logic [4:0]  iss_wd;
    logic        iss_full;
    logic        flush;
    logic        sb_err;

    regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .re1       (re1),
        .raddr1    (raddr1),
        .rdata1    (rdata1),
        .busy1     (busy1),
        .re2       (re2),
        .raddr2    (raddr2),
        .rdata2    (rdata2),
        .busy2     (busy2),
        .iss_valid (iss_valid),
        .iss_wd    (iss_wd),
        .iss_full  (iss_full),
        .flush     (flush),
        .sb_err    (sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rd1;
        logic        b1;
        logic [31:0] rd2;
        logic        b2;
        logic        full;
        logic        err;
        logic [5:0]  m;
    } exp_t;

    exp_t q[$];
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic expect_out(input string name, input logic [31:0] r1, input logic b1,
                              input logic [31:0] r2, input logic b2, input logic full,
                              input logic err, input logic [5:0] m);
        exp_t e;
        e.name = name; e.rd1 = r1; e.b1 = b1; e.rd2 = r2; e.b2 = b2;
        e.full = full; e.err = err; e.m = m;
        q.push_back(e);
    endtask

    task automatic idle();
        we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        iss_valid = 1'b0; iss_wd = '0; flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Monitor: the DUT outputs are combinational, so every cycle with a pending expectation is compared.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests_run++;
            if ((e.m[5] && rdata1 !== e.rd1) || (e.m[4] && busy1 !== e.b1) ||
                (e.m[3] && rdata2 !== e.rd2) || (e.m[2] && busy2 !== e.b2) ||
                (e.m[1] && iss_full !== e.full) || (e.m[0] && sb_err !== e.err)) begin
                tests_failed++;
                $display("FAIL %s: got rd1=%h b1=%b rd2=%h b2=%b full=%b err=%b, want rd1=%h b1=%b rd2=%h b2=%b full=%b err=%b",
                         e.name, rdata1, busy1, rdata2, busy2, iss_full, sb_err,
                         e.rd1, e.b1, e.rd2, e.b2, e.full, e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle();
        // Reset forces zero even with a matching write and read enabled.
        we = 1'b1; waddr = 5'd7; wdata = 32'h1111_1111;
        re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd5;
        expect_out("rst_state", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, M_ALL);
        step();
        step(); rst = 1'b0;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd7;
        expect_out("after_rst", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, M_ALL);

        step(); we = 1'b1; waddr = 5'd0; wdata = 32'hDEAD_BEEF;
        re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
        expect_out("x0_bypass", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, M_ALL);
        step(); re1 = 1'b1; raddr1 = 5'd0;
        expect_out("x0_read", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, M_ALL);

        step(); we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678;
        re1 = 1'b1; raddr1 = 5'd7; raddr2 = 5'd7;
        expect_out("bypass", 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, M_ALL);
        step(); re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
        expect_out("rd_after_wr", 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0, CHK, M_ALL);

        step(); rst = 1'b1;
        step(); rst = 1'b0; re1 = 1'b1; raddr1 = 5'd7;
        expect_out("rst_clears", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, M_ALL);

        // Two writers to x3, then retire both.
        step(); iss_valid = 1'b1; iss_wd = 5'd3; re1 = 1'b1; raddr1 = 5'd3;
        expect_out("iss1", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, M_ALL);
        step(); iss_valid = 1'b1; iss_wd = 5'd3; re1 = 1'b1; raddr1 = 5'd3;
        expect_out("iss2", 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, M_ALL);
        step(); re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
        expect_out("pend2", 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, M_ALL);
        step(); we = 1'b1; waddr = 5'd3; wdata = 32'hAAAA_0001; re1 = 1'b1; raddr1 = 5'd3;
        expect_out("retire1", 32'hAAAA_0001, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, M_ALL);
        step(); we = 1'b1; waddr = 5'd3; wdata = 32'hBBBB_0002;
        re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
        expect_out("retire2", 32'hBBBB_0002, 1'b0, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0, M_ALL);
        step(); re1 = 1'b1; raddr1 = 5'd3;
        expect_out("retired", 32'hBBBB_0002, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, M_ALL);

        // Simultaneous issue and retire on x9 with one writer outstanding.
        step(); iss_valid = 1'b1; iss_wd = 5'd9;
        step(); iss_valid = 1'b1; iss_wd = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h0000_9999;
        re1 = 1'b1; raddr1 = 5'd9;
        expect_out("iss_ret_x9", 32'h0000_9999, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, M_ALL);
        step(); re1 = 1'b1; raddr1 = 5'd9;
        expect_out("x9_still", 32'h0000_9999, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, M_ALL);
        step(); we = 1'b1; waddr = 5'd9; wdata = 32'h0000_9999;

        // Saturate x4.
        for (int k = 0; k < 7; k++) begin
            step(); iss_valid = 1'b1; iss_wd = 5'd4; re1 = 1'b1; raddr1 = 5'd4;
            if (k == 6) expect_out("sat_7th", 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, M_ALL);
        end
        step(); iss_valid = 1'b1; iss_wd = 5'd4; re1 = 1'b1; raddr1 = 5'd4;
        expect_out("sat_full", 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, M_ALL);
        step(); re1 = 1'b1; raddr1 = 5'd4;
        expect_out("sat_err", 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, CHK, M_ALL);
        step(); iss_valid = 1'b1; iss_wd = 5'd4;
        expect_out("sat_hold", 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, CHK, M_ALL);
        step(); we = 1'b1; waddr = 5'd4; wdata = 32'h0000_0044; re1 = 1'b1; raddr1 = 5'd4;
        expect_out("sat_dec", 32'h0000_0044, 1'b1, 32'h0, 1'b0, 1'b0, CHK, M_ALL);
        step(); iss_valid = 1'b1; iss_wd = 5'd4;
        expect_out("sat_room", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, CHK, M_ALL);

        step(); rst = 1'b1;
        step(); rst = 1'b0; re1 = 1'b1; raddr1 = 5'd4;
        expect_out("rst_pend", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, M_ALL);

        // Flush with pend[2]=2, pend[5]=1 and a concurrent write to x2.
        step(); iss_valid = 1'b1; iss_wd = 5'd2;
        step(); iss_valid = 1'b1; iss_wd = 5'd2;
        step(); iss_valid = 1'b1; iss_wd = 5'd5;
        step(); flush = 1'b1; we = 1'b1; waddr = 5'd2; wdata = 32'h0000_00A5;
        iss_valid = 1'b1; iss_wd = 5'd6;
        re1 = 1'b1; raddr1 = 5'd2; re2 = 1'b1; raddr2 = 5'd5;
        expect_out("flush_cyc", 32'h0000_00A5, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, M_ALL);
        step(); re1 = 1'b1; raddr1 = 5'd2; re2 = 1'b1; raddr2 = 5'd5;
        expect_out("post_flush", 32'h0000_00A5, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, M_ALL);
        step(); re1 = 1'b1; raddr1 = 5'd6;
        expect_out("flush_iss_drop", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, M_ALL);
        step(); we = 1'b1; waddr = 5'd2; wdata = 32'h0000_0077; re1 = 1'b1; raddr1 = 5'd2;
        expect_out("underflow_ret", 32'h0000_0077, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, M_ALL);
        step(); re1 = 1'b1; raddr1 = 5'd2;
        expect_out("underflow_after", 32'h0000_0077, 1'b0, 32'h0, 1'b0, 1'b0, CHK, M_ALL);
        step();

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
